// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Owner encoding, read-tag struct, default parameter values.
package dmem_arb_pkg;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_AUX = 1'b1;

  localparam int ADDR_W_D     = 15;
  localparam int DATA_W_D     = 16;
  localparam int RD_LAT_D     = 2;
  localparam int STARVE_LIM_D = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag shift register: one {valid, owner} entry per cycle of latency.
// Ports: push_valid/push_owner in, kill_cpu strobe, head_valid/head_owner out.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_D
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_owner,
  input  logic kill_cpu,
  output logic head_valid,
  output logic head_owner
);

  rd_tag_t pipe [RD_LAT];

  // A CPU entry shifting past a flush edge loses its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0].valid <= push_valid &&
        !(kill_cpu && push_owner == OWN_CPU);
      pipe[0].owner <= push_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i].valid <= pipe[i-1].valid &&
          !(kill_cpu && pipe[i-1].owner == OWN_CPU);
        pipe[i].owner <= pipe[i-1].owner;
      end
    end
  end

  assign head_valid = pipe[RD_LAT-1].valid;
  assign head_owner = pipe[RD_LAT-1].owner;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data-memory port between CPU and aux masters (CPU priority,
// starvation guard for aux); routes fixed-latency read data to its owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_D,
  parameter int DATA_W     = DATA_W_D,
  parameter int RD_LAT     = RD_LAT_D,
  parameter int STARVE_LIM = STARVE_LIM_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_wen,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  input  logic              c_flush,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_wen,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [ADDR_W-1:0] m_raddr,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [15:0]       conflict_cnt
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [SW-1:0] starve_cnt;
  logic          aux_pri;
  logic          c_gnt;
  logic          a_gnt;
  logic          push_valid;
  logic          push_owner;
  logic          head_valid;
  logic          head_owner;

  // Aux takes over only once it has waited STARVE_LIM cycles.
  always_comb begin
    aux_pri    = a_req_valid && (starve_cnt == LIM);
    c_gnt      = !rst && c_req_valid && !c_flush && !aux_pri;
    a_gnt      = !rst && a_req_valid && !c_gnt;
    push_valid = (c_gnt && !c_req_wen) || (a_gnt && !a_req_wen);
    push_owner = a_gnt ? OWN_AUX : OWN_CPU;
  end

  assign c_req_ready = c_gnt;
  assign a_req_ready = a_gnt;

  // Address/data mux defaults to the CPU fields when nobody is granted.
  assign m_wen   = (c_gnt && c_req_wen) || (a_gnt && a_req_wen);
  assign m_raddr = a_gnt ? a_req_addr  : c_req_addr;
  assign m_waddr = a_gnt ? a_req_addr  : c_req_addr;
  assign m_wdata = a_gnt ? a_req_wdata : c_req_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (a_req_valid && !a_gnt) begin
      if (starve_cnt != LIM) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (c_req_valid && a_req_valid && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_owner (push_owner),
    .kill_cpu   (c_flush),
    .head_valid (head_valid),
    .head_owner (head_owner)
  );

  assign c_rvalid = head_valid && head_owner == OWN_CPU;
  assign a_rvalid = head_valid && head_owner == OWN_AUX;
  assign c_rdata  = m_rdata;
  assign a_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a transaction-level model.
// Ports: none (top-level testbench).
module tb_dmem_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req_valid = 0, c_req_wen = 0, c_flush = 0;
  logic        a_req_valid = 0, a_req_wen = 0;
  logic [14:0] c_req_addr = '0, a_req_addr = '0;
  logic [15:0] c_req_wdata = '0, a_req_wdata = '0;
  logic        c_req_ready, a_req_ready, c_rvalid, a_rvalid, m_wen;
  logic [15:0] c_rdata, a_rdata, m_rdata, m_wdata, conflict_cnt;
  logic [14:0] m_raddr, m_waddr;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(15), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_req_wen(c_req_wen), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata), .c_flush(c_flush),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_wen(a_req_wen), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .m_raddr(m_raddr), .m_rdata(m_rdata), .m_wen(m_wen),
    .m_waddr(m_waddr), .m_wdata(m_wdata),
    .conflict_cnt(conflict_cnt)
  );

  // Memory environment: registered read of RD_LAT cycles, write at edge.
  logic [15:0] mem  [0:32767];
  logic [15:0] rpipe [RD_LAT];
  logic        lw;
  logic [14:0] lwa, lra;
  logic [15:0] lwd;

  always @(negedge clk) begin
    lw = m_wen; lwa = m_waddr; lwd = m_wdata; lra = m_raddr;
  end

  always @(posedge clk) begin
    if (lw) mem[lwa] = lwd;
    for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
    rpipe[0] = mem[lra];
  end

  assign m_rdata = rpipe[RD_LAT-1];

  // Reference model: expected responses as a list of (due cycle, owner, data).
  typedef struct {
    int          due;
    bit          aux;
    logic [15:0] data;
  } pend_t;

  pend_t       pend[$];
  logic [15:0] mmem [0:32767];
  int          m_starve = 0;
  int          m_conf = 0;
  int          cyc = 0;
  bit          c_acc = 0, a_acc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 7 + 4096);
  endfunction

  task automatic tick();
    logic        ec, ea, ecv, eav, ew;
    logic [15:0] ed;
    pend_t       keep[$];
    @(negedge clk);
    ec = 0; ea = 0;
    if (rst) begin
      pend.delete(); m_starve = 0; m_conf = 0;
    end else begin
      ec = c_req_valid && !c_flush &&
           !(a_req_valid && m_starve == STARVE_LIM);
      ea = a_req_valid && !ec;
    end
    ecv = 0; eav = 0; ed = '0;
    foreach (pend[i]) if (pend[i].due == cyc) begin
      if (pend[i].aux) eav = 1; else ecv = 1;
      ed = pend[i].data;
    end
    ew = (ec && c_req_wen) || (ea && a_req_wen);
    n_checks++;
    if (c_req_ready !== ec) begin
      n_fail++;
      $display("FAIL c_ready cyc %0d: got %b expected %b", cyc, c_req_ready, ec);
    end
    n_checks++;
    if (a_req_ready !== ea) begin
      n_fail++;
      $display("FAIL a_ready cyc %0d: got %b expected %b", cyc, a_req_ready, ea);
    end
    n_checks++;
    if (c_rvalid !== ecv || a_rvalid !== eav) begin
      n_fail++;
      $display("FAIL rvalid cyc %0d: got c%b a%b expected c%b a%b",
               cyc, c_rvalid, a_rvalid, ecv, eav);
    end
    if (ecv || eav) begin
      n_checks++;
      if ((ecv ? c_rdata : a_rdata) !== ed) begin
        n_fail++;
        $display("FAIL rdata cyc %0d: got %h expected %h",
                 cyc, ecv ? c_rdata : a_rdata, ed);
      end
    end
    n_checks++;
    if (m_wen !== ew) begin
      n_fail++;
      $display("FAIL m_wen cyc %0d: got %b expected %b", cyc, m_wen, ew);
    end
    if (ew) begin
      n_checks++;
      if (m_waddr !== (ea ? a_req_addr : c_req_addr) ||
          m_wdata !== (ea ? a_req_wdata : c_req_wdata)) begin
        n_fail++;
        $display("FAIL wr_bus cyc %0d: got %h/%h", cyc, m_waddr, m_wdata);
      end
    end else if (ec || ea) begin
      n_checks++;
      if (m_raddr !== (ea ? a_req_addr : c_req_addr)) begin
        n_fail++;
        $display("FAIL m_raddr cyc %0d: got %h expected %h",
                 cyc, m_raddr, ea ? a_req_addr : c_req_addr);
      end
    end
    n_checks++;
    if (conflict_cnt !== 16'(m_conf)) begin
      n_fail++;
      $display("FAIL conflict cyc %0d: got %0d expected %0d",
               cyc, conflict_cnt, m_conf);
    end
    @(posedge clk);
    if (!rst) begin
      foreach (pend[i])
        if (pend[i].due > cyc && !(c_flush && !pend[i].aux))
          keep.push_back(pend[i]);
      pend = keep;
      if (ec && c_req_wen) mmem[c_req_addr] = c_req_wdata;
      if (ea && a_req_wen) mmem[a_req_addr] = a_req_wdata;
      if (ec && !c_req_wen)
        pend.push_back('{cyc + RD_LAT, 1'b0, mmem[c_req_addr]});
      if (ea && !a_req_wen)
        pend.push_back('{cyc + RD_LAT, 1'b1, mmem[a_req_addr]});
      if (a_req_valid && !ea)
        m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
      else
        m_starve = 0;
      if (c_req_valid && a_req_valid && m_conf < 65535) m_conf++;
    end
    c_acc = ec; a_acc = ea;
    cyc++;
    #1;
  endtask

  task automatic idle();
    c_req_valid = 0; a_req_valid = 0; c_flush = 0;
  endtask

  task automatic test_reset();
    c_req_valid = 1; a_req_valid = 1; c_req_wen = 1; a_req_wen = 1;
    tick(); tick();
    n_checks++;
    if (conflict_cnt !== 16'h0 || c_rvalid !== 0 || a_rvalid !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt %0d rv %b%b expected 0 00",
               conflict_cnt, c_rvalid, a_rvalid);
    end
    idle(); rst = 0;
    tick();
  endtask

  task automatic test_cpu_read();
    c_req_valid = 1; c_req_wen = 0; c_req_addr = 15'h0010;
    tick();
    idle();
    n_checks++;
    if (c_rvalid !== 0) begin
      n_fail++;
      $display("FAIL cpu_read_early: got %b expected 0", c_rvalid);
    end
    tick();
    n_checks++;
    if (c_rvalid !== 1 || c_rdata !== 16'hBEEF || a_rvalid !== 0) begin
      n_fail++;
      $display("FAIL cpu_read: got v%b d%h a%b expected v1 dBEEF a0",
               c_rvalid, c_rdata, a_rvalid);
    end
    tick();
    n_checks++;
    if (c_rvalid !== 0) begin
      n_fail++;
      $display("FAIL cpu_read_late: got %b expected 0", c_rvalid);
    end
    tick();
  endtask

  task automatic test_starve();
    int          first = 0;
    logic [15:0] c0;
    c_req_valid = 1; c_req_wen = 0; c_req_addr = 15'h0030;
    a_req_valid = 1; a_req_wen = 1; a_req_addr = 15'h0020;
    a_req_wdata = 16'h1234;
    c0 = conflict_cnt;
    for (int k = 1; k <= 8 && first == 0; k++) begin
      #1;
      if (a_req_ready === 1'b1) first = k;
      tick();
    end
    a_req_valid = 0;
    n_checks++;
    if (first != 5) begin
      n_fail++;
      $display("FAIL starve_grant: got cycle %0d expected 5", first);
    end
    n_checks++;
    if (dut.starve_cnt !== 0) begin
      n_fail++;
      $display("FAIL starve_clear: got %0d expected 0", dut.starve_cnt);
    end
    n_checks++;
    if (conflict_cnt - c0 !== 16'd5) begin
      n_fail++;
      $display("FAIL starve_conflict: got %0d expected 5", conflict_cnt - c0);
    end
    tick();
    idle(); tick(); tick(); tick();
    n_checks++;
    if (mem[15'h0020] !== 16'h1234) begin
      n_fail++;
      $display("FAIL aux_write: got %h expected 1234", mem[15'h0020]);
    end
  endtask

  task automatic test_flush();
    c_req_valid = 1; c_req_wen = 0; c_req_addr = 15'h0040;
    tick();
    c_flush = 1;
    a_req_valid = 1; a_req_wen = 0; a_req_addr = 15'h0041;
    #1;
    n_checks++;
    if (c_req_ready !== 0 || a_req_ready !== 1) begin
      n_fail++;
      $display("FAIL flush_ready: got c%b a%b expected c0 a1",
               c_req_ready, a_req_ready);
    end
    tick();
    c_flush = 0; a_req_valid = 0;
    n_checks++;
    if (c_rvalid !== 0) begin
      n_fail++;
      $display("FAIL flush_drop: got %b expected 0", c_rvalid);
    end
    tick();
    c_req_valid = 0;
    n_checks++;
    if (a_rvalid !== 1 || c_rvalid !== 0 || a_rdata !== init_val(65)) begin
      n_fail++;
      $display("FAIL flush_aux: got a%b c%b d%h expected a1 c0 d%h",
               a_rvalid, c_rvalid, a_rdata, init_val(65));
    end
    tick(); tick(); tick();
  endtask

  task automatic test_wr_rd();
    c_req_valid = 1; c_req_wen = 1; c_req_addr = 15'h0005;
    c_req_wdata = 16'h00AA;
    tick();
    c_req_wen = 0;
    tick();
    idle();
    tick();
    n_checks++;
    if (c_rvalid !== 1 || c_rdata !== 16'h00AA) begin
      n_fail++;
      $display("FAIL wr_rd: got v%b d%h expected v1 d00AA", c_rvalid, c_rdata);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    c_acc = 0; a_acc = 0;
    for (int k = 0; k < 400; k++) begin
      if (!c_req_valid || c_acc) begin
        c_req_valid = ($urandom_range(0, 2) != 0);
        c_req_wen   = 1'($urandom_range(0, 1));
        c_req_addr  = 15'($urandom_range(0, 15));
        c_req_wdata = 16'($urandom);
      end
      if (!a_req_valid || a_acc) begin
        a_req_valid = ($urandom_range(0, 2) != 0);
        a_req_wen   = 1'($urandom_range(0, 1));
        a_req_addr  = 15'($urandom_range(0, 15));
        a_req_wdata = 16'($urandom);
      end
      c_flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_reset_async();
    bit seen = 0;
    c_req_valid = 1; c_req_wen = 0; c_req_addr = 15'h0050;
    tick();
    c_req_valid = 0;
    a_req_valid = 1; a_req_wen = 0; a_req_addr = 15'h0051;
    tick();
    a_req_valid = 0;
    #2 rst = 1;
    #1;
    n_checks++;
    if (c_rvalid !== 0 || a_rvalid !== 0 || conflict_cnt !== 0 ||
        dut.starve_cnt !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got rv %b%b cnt %0d st %0d expected 0",
               c_rvalid, a_rvalid, conflict_cnt, dut.starve_cnt);
    end
    tick(); tick();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      if (c_rvalid || a_rvalid) seen = 1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_inflight: got rvalid after reset expected none");
    end
  endtask

  task automatic test_saturate();
    c_req_valid = 1; c_req_wen = 1; c_req_addr = 15'h0100;
    a_req_valid = 1; a_req_wen = 1; a_req_addr = 15'h0101;
    for (int k = 0; k < 70000; k++) tick();
    idle();
    tick();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate: got %h expected FFFF", conflict_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = init_val(i);
      mmem[i] = init_val(i);
    end
    mem[16] = 16'hBEEF;
    mmem[16] = 16'hBEEF;
    for (int i = 0; i < RD_LAT; i++) rpipe[i] = '0;
    test_reset();
    test_cpu_read();
    test_starve();
    test_flush();
    test_wr_rd();
    test_random();
    test_reset_async();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the CPU's single data-memory access port (read port 1 plus the write port of `mem`) between two requesters: the pipeline's load/store path (CPU) and an auxiliary master (program loader / debug probe). Fixed priority to the CPU with a starvation guard for the auxiliary master. Sits between the execute/mem stages and `mem`. Tracks fixed-latency reads and routes read data back to the owner; CPU reads in flight are cancelled on pipeline flush.

## Interface
- `ADDR_W`, 15: word-address width; matches `mem` `raddr1_`/`waddr`.
- `DATA_W`, 16: data width.
- `RD_LAT`, 2: cycles from accepted read to valid `m_rdata`; legal range ≥1.
- `STARVE_LIM`, 4: aux-wait cycles before aux is forced through; legal range ≥1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `c_req_valid`, `a_req_valid`  in  1  request present (CPU / aux).
- `c_req_ready`, `a_req_ready`  out  1  request accepted this cycle.
- `c_req_wen`, `a_req_wen`  in  1  1 = write, 0 = read.
- `c_req_addr`, `a_req_addr`  in  ADDR_W  word address.
- `c_req_wdata`, `a_req_wdata`  in  DATA_W  write data.
- `c_flush`  in  1  pipeline flush; cancels CPU reads.
- `c_rvalid`, `a_rvalid`  out  1  read data valid for that owner.
- `c_rdata`, `a_rdata`  out  DATA_W  read data; both equal `m_rdata`.
- `m_raddr`  out  ADDR_W  memory read address.
- `m_rdata`  in  DATA_W  memory read data.
- `m_wen`  out  1  memory write enable.
- `m_waddr`  out  ADDR_W  memory write address.
- `m_wdata`  out  DATA_W  memory write data.
- `conflict_cnt`  out  16  saturating count of cycles with both requests valid.

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. The requester holds valid, wen, addr and wdata stable until it is accepted. Ready is combinational from the valids, the starve counter and `c_flush`.
- Grant, at most one per cycle:
  - Only one valid: that requester is granted.
  - Both valid: CPU wins unless `starve_cnt == STARVE_LIM`; in that case aux wins.
  - `c_flush` high forces `c_req_ready=0`, so aux may be granted that cycle.
- `starve_cnt`:
  - Increments, saturating at `STARVE_LIM`, when aux is valid and not granted.
  - Clears on aux grant or when `a_req_valid=0`.
- Granted write: `m_wen=1`, with `m_waddr`/`m_wdata` taken from the winner, in the grant cycle. No response is returned.
- Granted read: `m_raddr` = winner's addr in the grant cycle. An entry {valid, owner} enters the tag pipe.
- No grant: `m_wen=0`. `m_raddr`/`m_waddr`/`m_wdata` follow the CPU request fields (don't-care).
- Tag pipe: RD_LAT-deep shift register.
  - Its head drives `c_rvalid` or `a_rvalid` combinationally.
  - `c_flush` clears the valid bit of every CPU-owned entry, at the edge where `c_flush` is sampled high.
  - Aux entries are never cancelled.
- `conflict_cnt` increments on every cycle with both valids high; saturates at 16'hFFFF.
- Reset (async, any time): tag pipe emptied, `starve_cnt=0`, `conflict_cnt=0`.
  - Reads in flight at reset never produce rvalid.
  - While `rst` is high, both readys, both rvalids and `m_wen` are 0.

## Timing
- Read accepted at edge t: the owner's rvalid is high during cycle t+RD_LAT, with `*_rdata = m_rdata`.
- Write accepted at edge t: the memory is written at edge t.
- Back-to-back accepts are allowed every cycle. There is no response backpressure, and at most one rvalid is high per cycle.
- Write then read of the same address in consecutive cycles: the read returns the new data (the memory's write-before-read ordering).
- Flush and CPU read in the same cycle: no accept, because ready is 0. A CPU read accepted at t-1 with flush sampled at t is dropped.
- Reset values of all outputs: readys 0, rvalids 0, `m_wen` 0, `conflict_cnt` 0.

## Structure
- Package `dmem_arb_pkg`:
  - Owner encoding `OWN_CPU=1'b0`, `OWN_AUX=1'b1`.
  - Tag struct {valid, owner}.
  - Default parameter constants.
- Sub-module `rd_tag_pipe`: parameter RD_LAT. Ports: push valid/owner, kill-owner strobe, head valid/owner.
- Grant logic, starve counter and conflict counter live in the top module.

## Test plan
- CPU read only, addr 15'h0010, memory holds 16'hBEEF → `c_rvalid` high exactly 2 cycles after accept with `c_rdata=16'hBEEF`; `a_rvalid` stays 0.
- Both valid continuously, CPU reads, aux writes 16'h1234 to 15'h0020 → aux accepted on the 5th cycle (`STARVE_LIM=4`), `starve_cnt` returns to 0; `conflict_cnt` = number of overlap cycles.
- CPU read accepted at t, `c_flush` at t+1, aux read accepted at t+1 → no `c_rvalid` at t+2; `a_rvalid` at t+3 with correct data.
- CPU write 16'h00AA to 15'h0005 at t, CPU read 15'h0005 at t+1 → `c_rdata=16'h00AA` at t+3.
- Reset asserted asynchronously mid-cycle while two reads are in flight → no rvalid after release; counters read 0.
- Hold both valids high for 70000 cycles → `conflict_cnt` saturates at 16'hFFFF with no wrap.
